// File: rtl/jts16_rom_pkg.sv
// jts16_rom_pkg: shared types, slot ids and default ROM offsets for the gfx ROM responder
// No ports; provides the fetch FSM state type, slot indices and the SDRAM address helper.
package jts16_rom_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_ACK, ST_WAIT_DATA} state_t;
    localparam logic [1:0] SLOT_CHAR = 2'd0;
    localparam logic [1:0] SLOT_SCR1 = 2'd1;
    localparam logic [1:0] SLOT_SCR2 = 2'd2;
    localparam logic [1:0] SLOT_OBJ  = 2'd3;
    localparam logic [21:0] DEF_CHAR_OFFSET = 22'h00000;
    localparam logic [21:0] DEF_SCR_OFFSET  = 22'h08000;
    localparam logic [21:0] DEF_OBJ_OFFSET  = 22'h40000;
    // A 32-bit tag covers two 16-bit SDRAM words; the sum wraps at 22 bits.
    function automatic logic [21:0] word_addr(input logic [21:0] offset, input logic [16:0] tag);
        return offset + {4'd0, tag, 1'b0};
    endfunction
endpackage

// File: rtl/jts16_rom_slot.sv
// jts16_rom_slot: one-entry word cache for a single layer fetch port
// Ports: clk/rst_n; en gates the port; tag_in is the current request tag;
// wr/wr_tag/wr_data fill the entry; miss feeds the arbiter; ok/data are registered outputs.
module jts16_rom_slot #(
    parameter int TW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [TW-1:0] tag_in,
    input  logic          wr,
    input  logic [TW-1:0] wr_tag,
    input  logic [31:0]   wr_data,
    output logic          miss,
    output logic          ok,
    output logic [31:0]   data
);
    logic [TW-1:0] tag_q, tag_d;
    logic [31:0]   word_q, word_d, data_q, data_d;
    logic          valid_q, valid_d, ok_q, ok_d, hit;
    always_comb begin
        hit     = valid_q && (tag_q == tag_in);
        tag_d   = wr ? wr_tag : tag_q;
        word_d  = wr ? wr_data : word_q;
        valid_d = valid_q | wr;
        ok_d    = en && hit;
        data_d  = hit ? word_q : data_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            tag_q   <= tag_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ok_q    <= ok_d;
            data_q  <= data_d;
        end
    end
    assign miss = en && !hit;
    assign ok   = ok_q;
    assign data = data_q;
endmodule

// File: rtl/jts16_gfx_rom.sv
// jts16_gfx_rom: serves char/scr1/scr2/obj tile fetches from SDRAM through per-port word caches
// Ports: *_addr in / *_data, *_ok out per layer (obj_cs enables the obj port);
// sdram_req/sdram_addr out, sdram_ack/sdram_rdy/sdram_din in for the single SDRAM read channel.
module jts16_gfx_rom import jts16_rom_pkg::*; #(
    parameter logic [21:0] CHAR_OFFSET = DEF_CHAR_OFFSET,
    parameter logic [21:0] SCR_OFFSET  = DEF_SCR_OFFSET,
    parameter logic [21:0] OBJ_OFFSET  = DEF_OBJ_OFFSET
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] char_addr,
    output logic [31:0] char_data,
    output logic        char_ok,
    input  logic [16:0] scr1_addr,
    output logic [31:0] scr1_data,
    output logic        scr1_ok,
    input  logic [16:0] scr2_addr,
    output logic [31:0] scr2_data,
    output logic        scr2_ok,
    input  logic        obj_cs,
    input  logic [17:0] obj_addr,
    output logic [15:0] obj_data,
    output logic        obj_ok,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [31:0] sdram_din
);
    state_t            state_q, state_d;
    logic [1:0]        slot_q, slot_d, sel;
    logic [16:0]       tag_q, tag_d;
    logic              req_q, req_d, obj_half_q, obj_half_d, obj_ok_q;
    logic [21:0]       addr_q, addr_d;
    logic [3:0]        miss, wr;
    logic [3:0][16:0]  tags;
    logic [3:0][21:0]  addrs;
    logic [31:0]       obj_word;
    always_comb begin
        tags[SLOT_CHAR]  = {4'd0, char_addr};
        tags[SLOT_SCR1]  = scr1_addr;
        tags[SLOT_SCR2]  = scr2_addr;
        tags[SLOT_OBJ]   = obj_addr[17:1];
        addrs[SLOT_CHAR] = word_addr(CHAR_OFFSET, tags[SLOT_CHAR]);
        addrs[SLOT_SCR1] = word_addr(SCR_OFFSET, tags[SLOT_SCR1]);
        addrs[SLOT_SCR2] = word_addr(SCR_OFFSET, tags[SLOT_SCR2]);
        addrs[SLOT_OBJ]  = word_addr(OBJ_OFFSET, tags[SLOT_OBJ]);
        sel = miss[SLOT_CHAR] ? SLOT_CHAR : miss[SLOT_SCR1] ? SLOT_SCR1 :
              miss[SLOT_SCR2] ? SLOT_SCR2 : SLOT_OBJ;
        state_d    = state_q;
        slot_d     = slot_q;
        tag_d      = tag_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wr         = '0;
        obj_half_d = obj_addr[0];
        case (state_q)
            ST_IDLE: if (|miss) begin
                slot_d  = sel;
                tag_d   = tags[sel];
                addr_d  = addrs[sel];
                req_d   = 1'b1;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: if (sdram_ack) begin
                req_d   = 1'b0;
                state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: if (sdram_rdy) begin
                // Fill uses the latched slot/tag, so an address change mid-fetch lands under the old tag.
                wr[slot_q] = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            slot_q     <= SLOT_CHAR;
            tag_q      <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            obj_half_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            tag_q      <= tag_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            obj_half_q <= obj_half_d;
        end
    end
    jts16_rom_slot #(.TW(13)) u_char (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .tag_in(char_addr),
        .wr(wr[SLOT_CHAR]), .wr_tag(tag_q[12:0]), .wr_data(sdram_din),
        .miss(miss[SLOT_CHAR]), .ok(char_ok), .data(char_data)
    );
    jts16_rom_slot #(.TW(17)) u_scr1 (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .tag_in(scr1_addr),
        .wr(wr[SLOT_SCR1]), .wr_tag(tag_q), .wr_data(sdram_din),
        .miss(miss[SLOT_SCR1]), .ok(scr1_ok), .data(scr1_data)
    );
    jts16_rom_slot #(.TW(17)) u_scr2 (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .tag_in(scr2_addr),
        .wr(wr[SLOT_SCR2]), .wr_tag(tag_q), .wr_data(sdram_din),
        .miss(miss[SLOT_SCR2]), .ok(scr2_ok), .data(scr2_data)
    );
    jts16_rom_slot #(.TW(17)) u_obj (
        .clk(clk), .rst_n(rst_n), .en(obj_cs), .tag_in(obj_addr[17:1]),
        .wr(wr[SLOT_OBJ]), .wr_tag(tag_q), .wr_data(sdram_din),
        .miss(miss[SLOT_OBJ]), .ok(obj_ok_q), .data(obj_word)
    );
    // obj_ok drops combinationally with obj_cs; the half select is registered to track obj_word.
    assign obj_ok     = obj_ok_q && obj_cs;
    assign obj_data   = obj_half_q ? obj_word[31:16] : obj_word[15:0];
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
endmodule

// File: tb/tb_jts16_gfx_rom.sv
// tb_jts16_gfx_rom: randomized and directed checks of jts16_gfx_rom against a cache-level model
module tb_jts16_gfx_rom;
    localparam logic [21:0] CHAR_OFF = 22'h00000;
    localparam logic [21:0] SCR_OFF  = 22'h08000;
    localparam logic [21:0] OBJ_OFF  = 22'h40000;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [12:0] char_addr = '0;
    logic [16:0] scr1_addr = '0, scr2_addr = '0;
    logic [17:0] obj_addr = '0;
    logic        obj_cs = 1'b0, sdram_ack = 1'b0, sdram_rdy = 1'b0;
    logic [31:0] sdram_din = '0;
    logic [31:0] char_data, scr1_data, scr2_data;
    logic [15:0] obj_data;
    logic        char_ok, scr1_ok, scr2_ok, obj_ok, sdram_req;
    logic [21:0] sdram_addr;
    int          n_tests = 0, n_fail = 0;
    logic [21:0] ovr_addr = '1;
    logic [31:0] ovr_data = '0;

    jts16_gfx_rom dut (
        .clk(clk), .rst_n(rst_n),
        .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
        .scr1_addr(scr1_addr), .scr1_data(scr1_data), .scr1_ok(scr1_ok),
        .scr2_addr(scr2_addr), .scr2_data(scr2_data), .scr2_ok(scr2_ok),
        .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // SDRAM contents: the two halves always differ so half selection is observable.
    function automatic logic [31:0] mem_data(input logic [21:0] a);
        return {a[15:0] ^ 16'h1357, a[15:0] ^ 16'hBEEF};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        ovr_addr = '1;
        tick();
        tick();
    endtask

    task automatic wait_req(output logic [21:0] a);
        int n;
        n = 0;
        while (sdram_req !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        n_tests++;
        if (sdram_req !== 1'b1) begin
            n_fail++;
            $display("FAIL req_timeout req=%b want 1", sdram_req);
        end
        a = sdram_addr;
    endtask

    task automatic complete(input int ad, input int rd, input logic [21:0] a, input logic [31:0] d);
        repeat (ad) tick();
        n_tests++;
        if (sdram_req !== 1'b1 || sdram_addr !== a) begin
            n_fail++;
            $display("FAIL req_hold got req=%b addr=%h want req=1 addr=%h", sdram_req, sdram_addr, a);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        n_tests++;
        if (sdram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL req_drop got req=%b want 0", sdram_req);
        end
        repeat (rd) tick();
        sdram_rdy = 1'b1;
        sdram_din = d;
        tick();
        sdram_rdy = 1'b0;
        sdram_din = $urandom;
    endtask

    task automatic serve(output logic [21:0] a);
        wait_req(a);
        complete(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), a,
                 (a == ovr_addr) ? ovr_data : mem_data(a));
    endtask

    task automatic drain(output int cnt);
        logic [21:0] a;
        int n;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            n = 0;
            while (sdram_req !== 1'b1 && n < 12) begin
                tick();
                n++;
            end
            if (sdram_req !== 1'b1) break;
            serve(a);
            cnt++;
        end
    endtask

    task automatic test_reset();
        char_addr = 13'h1; scr1_addr = 17'h2; scr2_addr = 17'h3; obj_addr = 18'h4; obj_cs = 1'b1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sdram_req, sdram_addr, char_ok, scr1_ok, scr2_ok, obj_ok,
             char_data, scr1_data, scr2_data, obj_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals req=%b addr=%h ok=%b%b%b%b cd=%h s1=%h s2=%h od=%h want all 0",
                     sdram_req, sdram_addr, char_ok, scr1_ok, scr2_ok, obj_ok,
                     char_data, scr1_data, scr2_data, obj_data);
        end
        tick();
        tick();
        n_tests++;
        if (sdram_req !== 1'b0 || obj_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold req=%b obj_ok=%b want 0 0", sdram_req, obj_ok);
        end
    endtask

    task automatic test_cold_char();
        int cnt;
        do_reset();
        char_addr = 13'h0123; scr1_addr = '0; scr2_addr = '0; obj_cs = 1'b0;
        ovr_addr = 22'h000246; ovr_data = 32'hDEADBEEF;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h000246) begin
            n_fail++;
            $display("FAIL cold_req got req=%b addr=%h want 1 000246", sdram_req, sdram_addr);
        end
        complete(3, 4, 22'h000246, 32'hDEADBEEF);
        n_tests++;
        if (char_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL cold_ok_early got %b want 0", char_ok);
        end
        tick();
        n_tests++;
        if (char_ok !== 1'b1 || char_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL cold_data got ok=%b data=%h want 1 deadbeef", char_ok, char_data);
        end
        drain(cnt);
        n_tests++;
        if (cnt != 2) begin
            n_fail++;
            $display("FAIL cold_rest got %0d requests want 2", cnt);
        end
    endtask

    task automatic test_all_four();
        logic [21:0] exp_a [4];
        logic [21:0] a;
        logic [17:0] oa;
        int cnt;
        do_reset();
        char_addr = 13'($urandom); scr1_addr = 17'($urandom); scr2_addr = 17'($urandom);
        oa = 18'($urandom); obj_addr = oa; obj_cs = 1'b1;
        exp_a[0] = CHAR_OFF + {char_addr, 1'b0};
        exp_a[1] = SCR_OFF + {scr1_addr, 1'b0};
        exp_a[2] = SCR_OFF + {scr2_addr, 1'b0};
        exp_a[3] = OBJ_OFF + {oa[17:1], 1'b0};
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(a);
            n_tests++;
            if (a !== exp_a[i]) begin
                n_fail++;
                $display("FAIL order_%0d got %h want %h", i, a, exp_a[i]);
            end
        end
        drain(cnt);
        n_tests++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL order_extra got %0d extra requests want 0", cnt);
        end
        n_tests++;
        if ({char_ok, scr1_ok, scr2_ok, obj_ok} !== 4'b1111 || char_data !== mem_data(exp_a[0]) ||
            scr1_data !== mem_data(exp_a[1]) || scr2_data !== mem_data(exp_a[2]) ||
            obj_data !== (oa[0] ? mem_data(exp_a[3])[31:16] : mem_data(exp_a[3])[15:0])) begin
            n_fail++;
            $display("FAIL order_final ok=%b cd=%h s1=%h s2=%h od=%h want 1111 %h %h %h",
                     {char_ok, scr1_ok, scr2_ok, obj_ok}, char_data, scr1_data, scr2_data, obj_data,
                     mem_data(exp_a[0]), mem_data(exp_a[1]), mem_data(exp_a[2]));
        end
    endtask

    task automatic test_obj_half();
        int cnt;
        bit seen;
        do_reset();
        char_addr = 13'h1; scr1_addr = 17'h2; scr2_addr = 17'h3;
        obj_cs = 1'b1; obj_addr = 18'h00005;
        ovr_addr = OBJ_OFF + 22'h4; ovr_data = 32'hAAAA5555;
        rst_n = 1'b1;
        drain(cnt);
        n_tests++;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL half_reqs got %0d want 4", cnt);
        end
        n_tests++;
        if (obj_ok !== 1'b1 || obj_data !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL half_hi got ok=%b data=%h want 1 aaaa", obj_ok, obj_data);
        end
        obj_addr = 18'h00004;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sdram_req !== 1'b0 || obj_ok !== 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen || obj_data !== 16'h5555) begin
            n_fail++;
            $display("FAIL half_lo got data=%h glitch=%b want 5555 0", obj_data, seen);
        end
    endtask

    task automatic test_addr_change();
        logic [21:0] a;
        bit seen;
        do_reset();
        char_addr = 13'h7; scr1_addr = 17'h00010; scr2_addr = 17'h00040; obj_cs = 1'b0;
        rst_n = 1'b1;
        serve(a);
        wait_req(a);
        n_tests++;
        if (a !== SCR_OFF + 22'h20) begin
            n_fail++;
            $display("FAIL chg_first got %h want %h", a, SCR_OFF + 22'h20);
        end
        sdram_rdy = 1'b1;
        sdram_din = 32'h0BAD0BAD;
        tick();
        sdram_rdy = 1'b0;
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        tick();
        scr1_addr = 17'h00011;
        tick();
        sdram_rdy = 1'b1;
        sdram_din = mem_data(a);
        tick();
        sdram_rdy = 1'b0;
        tick();
        n_tests++;
        if (scr1_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_ok got %b want 0", scr1_ok);
        end
        wait_req(a);
        n_tests++;
        if (a !== SCR_OFF + 22'h22) begin
            n_fail++;
            $display("FAIL chg_second got %h want %h", a, SCR_OFF + 22'h22);
        end
        complete(1, 1, a, mem_data(a));
        tick();
        n_tests++;
        if (scr1_ok !== 1'b1 || scr1_data !== mem_data(SCR_OFF + 22'h22)) begin
            n_fail++;
            $display("FAIL chg_refill got ok=%b data=%h want 1 %h", scr1_ok, scr1_data, mem_data(SCR_OFF + 22'h22));
        end
        wait_req(a);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        tick();
        sdram_rdy = 1'b1;
        sdram_din = mem_data(a);
        scr2_addr = 17'h00041;
        tick();
        sdram_rdy = 1'b0;
        scr2_addr = 17'h00040;
        n_tests++;
        if (scr2_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_ok got %b want 0", scr2_ok);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sdram_req !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen || scr2_ok !== 1'b1 || scr2_data !== mem_data(SCR_OFF + 22'h80)) begin
            n_fail++;
            $display("FAIL same_cycle_tag got ok=%b data=%h extra_req=%b want 1 %h 0",
                     scr2_ok, scr2_data, seen, mem_data(SCR_OFF + 22'h80));
        end
    endtask

    task automatic test_obj_cs();
        logic [21:0] a;
        logic [17:0] oa;
        int cnt;
        do_reset();
        char_addr = 13'h20; scr1_addr = 17'h30; scr2_addr = 17'h31;
        oa = 18'($urandom); obj_addr = oa; obj_cs = 1'b0;
        rst_n = 1'b1;
        drain(cnt);
        n_tests++;
        if (cnt != 3 || obj_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL cs_off got reqs=%0d obj_ok=%b want 3 0", cnt, obj_ok);
        end
        obj_cs = 1'b1;
        tick();
        a = OBJ_OFF + {oa[17:1], 1'b0};
        n_tests++;
        if (sdram_req !== 1'b1 || sdram_addr !== a) begin
            n_fail++;
            $display("FAIL cs_on_req got req=%b addr=%h want 1 %h", sdram_req, sdram_addr, a);
        end
        complete(0, 0, a, mem_data(a));
        tick();
        n_tests++;
        if (obj_ok !== 1'b1 || obj_data !== (oa[0] ? mem_data(a)[31:16] : mem_data(a)[15:0])) begin
            n_fail++;
            $display("FAIL cs_on_data got ok=%b data=%h", obj_ok, obj_data);
        end
        obj_cs = 1'b0;
        #1;
        n_tests++;
        if (obj_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL cs_drop got %b want 0", obj_ok);
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] a;
        int cnt;
        do_reset();
        char_addr = 13'h55; scr1_addr = 17'h1; scr2_addr = 17'h2; obj_cs = 1'b0;
        rst_n = 1'b1;
        wait_req(a);
        tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (sdram_req !== 1'b0 || sdram_addr !== '0 || {char_ok, scr1_ok, scr2_ok, obj_ok} !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_reset got req=%b addr=%h ok=%b want 0 0 0", sdram_req, sdram_addr,
                     {char_ok, scr1_ok, scr2_ok, obj_ok});
        end
        tick();
        rst_n = 1'b1;
        sdram_rdy = 1'b1;
        sdram_din = 32'hFEEDF00D;
        tick();
        sdram_rdy = 1'b0;
        tick();
        n_tests++;
        if (char_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_rdy got char_ok=%b want 0", char_ok);
        end
        wait_req(a);
        n_tests++;
        if (a !== CHAR_OFF + 22'hAA) begin
            n_fail++;
            $display("FAIL stray_refetch got %h want %h", a, CHAR_OFF + 22'hAA);
        end
        complete(0, 2, a, mem_data(a));
        drain(cnt);
    endtask

    task automatic test_random();
        logic [21:0] offs [4];
        logic [16:0] m_tag [4];
        bit          m_valid [4];
        logic [16:0] ta [4];
        logic [21:0] exp_q [$];
        logic [21:0] a, oaddr;
        logic [17:0] oa;
        logic        cs;
        bit          seen;
        offs[0] = CHAR_OFF; offs[1] = SCR_OFF; offs[2] = SCR_OFF; offs[3] = OBJ_OFF;
        for (int p = 0; p < 4; p++) begin
            m_valid[p] = 1'b0;
            m_tag[p] = '0;
        end
        do_reset();
        char_addr = '0; scr1_addr = '0; scr2_addr = '0; obj_addr = '0; obj_cs = 1'b0;
        rst_n = 1'b1;
        for (int it = 0; it < 25; it++) begin
            ta[0] = 17'($urandom_range(0, 3));
            ta[1] = 17'($urandom_range(0, 3));
            ta[2] = 17'($urandom_range(0, 3));
            oa = 18'($urandom_range(0, 7));
            ta[3] = oa[17:1];
            cs = ($urandom_range(0, 3) != 0);
            char_addr = ta[0][12:0]; scr1_addr = ta[1]; scr2_addr = ta[2]; obj_addr = oa; obj_cs = cs;
            exp_q.delete();
            for (int p = 0; p < 4; p++) begin
                if ((p != 3 || cs) && !(m_valid[p] && m_tag[p] == ta[p])) begin
                    exp_q.push_back(offs[p] + {ta[p], 1'b0});
                    m_valid[p] = 1'b1;
                    m_tag[p] = ta[p];
                end
            end
            foreach (exp_q[i]) begin
                serve(a);
                n_tests++;
                if (a !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rnd_addr it=%0d req=%0d got %h want %h", it, i, a, exp_q[i]);
                end
            end
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (sdram_req !== 1'b0) seen = 1'b1;
            end
            n_tests++;
            if (seen || {char_ok, scr1_ok, scr2_ok, obj_ok} !== {3'b111, cs}) begin
                n_fail++;
                $display("FAIL rnd_ok it=%0d got ok=%b extra_req=%b want %b 0", it,
                         {char_ok, scr1_ok, scr2_ok, obj_ok}, seen, {3'b111, cs});
            end
            oaddr = offs[3] + {ta[3], 1'b0};
            n_tests++;
            if (char_data !== mem_data(offs[0] + {ta[0], 1'b0}) ||
                scr1_data !== mem_data(offs[1] + {ta[1], 1'b0}) ||
                scr2_data !== mem_data(offs[2] + {ta[2], 1'b0}) ||
                (cs && obj_data !== (oa[0] ? mem_data(oaddr)[31:16] : mem_data(oaddr)[15:0]))) begin
                n_fail++;
                $display("FAIL rnd_data it=%0d cd=%h s1=%h s2=%h od=%h", it,
                         char_data, scr1_data, scr2_data, obj_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_char();
        test_all_four();
        test_obj_half();
        test_addr_change();
        test_obj_cs();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
